// File: rtl/pipe_buf_stage.sv
// pipe_buf_stage
//   Two-entry pipeline buffer between fetch and decode. MAIN drives the
//   output and SKID catches the payload accepted in the cycle that the
//   downstream stalls. in_ready depends on state only, so there is no
//   combinational path from out_ready to in_ready. There is also no
//   combinational path from in_data to out_data. A flush empties the stage
//   and adds the discarded entries to a saturating counter.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload (state only)
//   in_data    upstream payload
//   flush      discard held and incoming payloads
//   out_valid  downstream payload valid
//   out_ready  downstream accepts the payload
//   out_data   MAIN when valid, NOP_VAL otherwise
//   occupancy  held entries, 0..2
//   drop_cnt   saturating count of entries discarded by flush
module pipe_buf_stage #(
    parameter int                 DATA_W  = 41,
    parameter logic [DATA_W-1:0]  NOP_VAL = {9'h0, 32'h00000013},
    parameter int                 CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CNT_W-1:0]  drop_nxt;
    logic              push, pop;
    logic              main_ld, main_from_skid, skid_ld;
    logic [1:0]        drop_amt;

    // The counter only ever grows by 0..2, so one extra bit is enough to
    // detect overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        occupancy = 2'd0;
        case (state)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = out_valid ? main_data : NOP_VAL;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // A pop in the flush cycle is a delivery, and a push in the flush cycle
    // is a drop. occupancy >= pop always, so this never underflows.
    assign drop_amt = occupancy - {1'b0, pop} + {1'b0, push};

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        drop_nxt       = drop_cnt;
        if (flush) begin
            state_nxt = EMPTY;
            drop_nxt  = sat_add(drop_cnt, drop_amt);
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_ld   = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_ld   = 1'b1;
                        state_nxt = FULL;
                    end else if (pop && !push) begin
                        state_nxt = EMPTY;
                    end else if (push && pop) begin
                        main_ld = 1'b1;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_from_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            drop_cnt  <= '0;
            main_data <= NOP_VAL;
            skid_data <= NOP_VAL;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
            if (main_ld)
                main_data <= in_data;
            else if (main_from_skid)
                main_data <= skid_data;
            if (skid_ld)
                skid_data <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_buf_stage.sv
module tb_pipe_buf_stage;

    localparam int          DATA_W = 41;
    localparam logic [40:0] NOP    = {9'h0, 32'h00000013};
    localparam logic [40:0] A      = 41'h1_00000093;
    localparam logic [40:0] B      = 41'h2_00000113;

    logic              clk = 1'b0;
    logic              reset, in_valid, flush, out_ready;
    logic [DATA_W-1:0] in_data;

    logic              in_ready, out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [7:0]        drop_cnt;

    logic              s_in_ready, s_out_valid;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_occupancy;
    logic [1:0]        s_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_buf_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
        .drop_cnt(drop_cnt)
    );

    pipe_buf_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .occupancy(s_occupancy),
        .drop_cnt(s_drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        reset = 1'b0;

        // reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'(NOP));
        check("rst_occ",       64'(occupancy), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_drop",      64'(drop_cnt),  64'd0);

        // fill
        in_valid = 1'b1; in_data = A; tick();
        check("fill1_occ",  64'(occupancy), 64'd1);
        check("fill1_data", 64'(out_data),  64'(A));
        check("fill1_rdy",  64'(in_ready),  64'd1);
        in_data = B; tick();
        check("fill2_occ",  64'(occupancy), 64'd2);
        check("fill2_rdy",  64'(in_ready),  64'd0);
        check("fill2_data", 64'(out_data),  64'(A));
        in_valid = 1'b0;

        // drain
        out_ready = 1'b1; tick();
        check("drain1_data", 64'(out_data),  64'(B));
        check("drain1_occ",  64'(occupancy), 64'd1);
        tick();
        check("drain2_valid", 64'(out_valid), 64'd0);
        check("drain2_data",  64'(out_data),  64'(NOP));
        check("drain2_occ",   64'(occupancy), 64'd0);

        // streaming
        in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = DATA_W'(i);
            tick();
            check("stream_data", 64'(out_data),  64'(i));
            check("stream_occ",  64'(occupancy), 64'd1);
            check("stream_rdy",  64'(in_ready),  64'd1);
        end
        in_valid = 1'b0; tick();
        check("stream_end_occ", 64'(occupancy), 64'd0);
        check("stream_drop",    64'(drop_cnt),  64'd0);
        out_ready = 1'b0;

        // flush in FULL with a simultaneous pop: 2 held - 1 popped = 1 dropped
        in_valid = 1'b1; in_data = 41'h0_0000AAAA; tick();
        in_data = 41'h0_0000BBBB; tick();
        check("pre_flush_full_occ", 64'(occupancy), 64'd2);
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1; tick();
        flush = 1'b0; out_ready = 1'b0;
        check("flush_full_occ",   64'(occupancy), 64'd0);
        check("flush_full_valid", 64'(out_valid), 64'd0);
        check("flush_full_drop",  64'(drop_cnt),  64'd1);

        // flush in ONE with a simultaneous push: 1 held + 1 pushed = 2 dropped
        in_valid = 1'b1; in_data = 41'h0_0000CCCC; tick();
        check("pre_flush_one_occ", 64'(occupancy), 64'd1);
        in_data = 41'h0_0000DDDD; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_one_occ",  64'(occupancy), 64'd0);
        check("flush_one_data", 64'(out_data),  64'(NOP));
        check("flush_one_drop", 64'(drop_cnt),  64'd3);
        // the pushed payload must not have been kept
        tick();
        check("flush_one_after_valid", 64'(out_valid), 64'd0);

        // saturation: restart both counters, then four flushes each dropping 1
        reset = 1'b1; tick(); reset = 1'b0;
        check("sat_start", 64'(s_drop_cnt), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_data = DATA_W'(k); tick();
            in_valid = 1'b0; flush = 1'b1; tick();
            flush = 1'b0;
            check("sat_drop",  64'(s_drop_cnt), (k >= 3) ? 64'd3 : 64'(k));
            check("wide_drop", 64'(drop_cnt),   64'(k));
        end

        // reset in FULL with flush: reset wins and nothing is counted
        in_valid = 1'b1; in_data = A; tick();
        in_data = B; tick();
        check("pre_rst_occ", 64'(occupancy), 64'd2);
        in_valid = 1'b0; reset = 1'b1; flush = 1'b1; tick();
        reset = 1'b0; flush = 1'b0;
        check("rst_full_occ",   64'(occupancy), 64'd0);
        check("rst_full_drop",  64'(drop_cnt),  64'd0);
        check("rst_full_data",  64'(out_data),  64'(NOP));
        check("rst_full_rdy",   64'(in_ready),  64'd1);
        check("rst_full_sdrop", 64'(s_drop_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_buf_stage.md
PIPE_BUF_STAGE -- requirements
Module: pipe_buf_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 41, giving the payload width (the fetch/decode pair: 9-bit PC plus 32-bit instruction).
REQ-002 The block SHALL have parameter NOP_VAL, default {9'h0, 32'h00000013}, giving the payload presented while the output is not valid.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the flush-drop counter width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The ports SHALL be:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous reset, active-high
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept a payload this cycle
- in_data  in  DATA_W  upstream payload
- flush  in  1  discard all held and incoming payloads
- out_valid  out  1  downstream payload valid
- out_ready  in  1  downstream accepts the payload
- out_data  out  DATA_W  downstream payload
- occupancy  out  2  number of held entries, 0 to 2
- drop_cnt  out  CNT_W  saturating count of entries discarded by flush

Function
REQ-006 The block SHALL hold two entries: MAIN, which drives out_data, and SKID, which is overflow storage.
REQ-007 The state SHALL be one of EMPTY (occupancy 0), ONE (occupancy 1, MAIN valid) or FULL (occupancy 2, MAIN and SKID valid).
REQ-008 A push SHALL occur when in_valid & in_ready; a pop SHALL occur when out_valid & out_ready.
REQ-009 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, and SHALL be driven from state only, with no combinational path from out_ready.
REQ-010 out_valid SHALL be 1 in ONE and FULL.
REQ-011 out_data SHALL equal MAIN when out_valid=1 and NOP_VAL otherwise.
REQ-012 In EMPTY, a push SHALL load MAIN and go to ONE, so latency is 1 cycle: data pushed at edge N is visible on out_data after edge N.
REQ-013 In ONE, the transitions SHALL be:
- push, no pop: load SKID, go to FULL
- pop, no push: go to EMPTY
- push and pop: load MAIN with in_data, stay ONE
REQ-014 In FULL, a pop SHALL move SKID into MAIN and go to ONE; no push is possible in FULL.
REQ-015 Payload order SHALL be preserved: no entry is dropped or duplicated except by flush.
REQ-016 flush SHALL have priority over push and pop: at the next edge the state becomes EMPTY and any simultaneous push is discarded.
REQ-017 On flush, drop_cnt SHALL add the discarded count: occupancy, minus 1 if a pop occurs that same cycle, plus 1 if a push occurs that same cycle.
REQ-018 drop_cnt SHALL saturate at all-ones and never wrap.
REQ-019 Each pop SHALL be counted as delivered, not dropped, even when flush is asserted in the same cycle.
REQ-020 The block SHALL have no combinational path from in_data to out_data.

Reset
REQ-021 While reset=1 at an edge, the state SHALL become EMPTY, drop_cnt 0, and MAIN and SKID NOP_VAL.
REQ-022 After that edge, out_valid=0, out_data=NOP_VAL, occupancy=0 and in_ready=1.
REQ-023 reset SHALL have priority over flush, push and pop.
REQ-024 A reset asserted mid-operation SHALL discard held entries without adding them to drop_cnt.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Fill: out_ready=0, push A=41'h1_00000093 then B=41'h2_00000113 -> occupancy 1 then 2, in_ready=0, out_data=A.
- Drain: from the Fill state, out_ready=1 for 2 cycles -> out_data A then B, then out_valid=0, out_data=41'h0_00000013.
- Streaming: in_valid=1, out_ready=1 for 10 cycles with data 1..10 -> outputs 1..10 in order, 1-cycle latency, occupancy stays 1, in_ready stays 1.
- Flush in FULL with a pop in the same cycle -> next cycle EMPTY, drop_cnt=1.
- Flush in ONE with a push in the same cycle -> next cycle EMPTY, drop_cnt +2.
- Saturation: CNT_W=2, four flushes each dropping 1 -> drop_cnt 1,2,3,3.
- Reset in FULL with flush=1 -> occupancy 0, drop_cnt 0, out_data=NOP_VAL.
